// File: rtl/request_queue.sv
// In-order request queue between the trace parser and the DRAM scheduler.
// First-word-fall-through head port with per-entry saturating age counters.
module request_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 16,
  parameter int AGE_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       op_ready_s,
  input  logic [1:0]                 opcode,
  input  logic [ADDRESS_WIDTH-1:0]   address,
  output logic                       q_full,
  input  logic                       deq_req,
  output logic                       head_valid,
  output logic [1:0]                 head_opcode,
  output logic [ADDRESS_WIDTH-1:0]   head_address,
  output logic [AGE_WIDTH-1:0]       head_age,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       drop_err,
  output logic                       illegal_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    Q_EMPTY,
    Q_PARTIAL,
    Q_FULL
  } q_state_t;

  q_state_t               q_state;
  logic [PW-1:0]          wp, rp;
  logic [CW-1:0]          cnt;
  logic [1:0]             op_mem   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [AGE_WIDTH-1:0]   age_mem  [DEPTH];
  logic [DEPTH-1:0]       entry_valid;
  logic                   empty, full, legal, enq, deq;

  always_comb begin
    q_state = Q_PARTIAL;
    if (cnt == '0)
      q_state = Q_EMPTY;
    else if (cnt == CW'(DEPTH))
      q_state = Q_FULL;
  end

  assign empty = (q_state == Q_EMPTY);
  assign full  = (q_state == Q_FULL);
  assign legal = (opcode != OP_ILLEGAL);
  assign deq   = deq_req & ~empty;
  assign enq   = op_ready_s & legal & (~full | deq);

  // An entry is live when its distance from rp (mod DEPTH) is below cnt.
  always_comb begin
    entry_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      entry_valid[i] = ({1'b0, PW'(PW'(i) - rp)} < cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      drop_err    <= 1'b0;
      illegal_err <= 1'b0;
    end else begin
      if (enq) wp <= wp + 1'b1;
      if (deq) rp <= rp + 1'b1;
      case ({enq, deq})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      drop_err    <= op_ready_s & legal & full & ~deq_req;
      illegal_err <= op_ready_s & ~legal;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      op_mem[wp]   <= opcode;
      addr_mem[wp] <= address;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        age_mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (enq && (PW'(i) == wp))
          age_mem[i] <= '0;
        else if (entry_valid[i] && (age_mem[i] != '1))
          age_mem[i] <= age_mem[i] + 1'b1;
      end
    end
  end

  assign q_full       = full;
  assign occupancy    = cnt;
  assign head_valid   = ~empty;
  assign head_opcode  = empty ? '0 : op_mem[rp];
  assign head_address = empty ? '0 : addr_mem[rp];
  assign head_age     = empty ? '0 : age_mem[rp];

endmodule

// File: doc/request_queue.md
# request_queue

Bounded in-order queue between the trace parser and the DRAM command scheduler. Accepts each request the parser presents (opcode + address), stamps it with an age counter, holds up to DEPTH requests, and presents the oldest one to the scheduler through a first-word-fall-through head port. Back-pressures the parser when full and flags lost or illegal requests.

## Interface
- ADDRESS_WIDTH, 32, request address width; matches the parser.
- DEPTH, 16, number of entries; power of two, at least 2.
- AGE_WIDTH, 8, width of each entry's age counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_ready_s  in  1  parser output: request valid this cycle.
- opcode  in  parsed_op_t  request type from global_defs (0 read, 1 write, 2 fetch, 3 illegal).
- address  in  ADDRESS_WIDTH  request address.
- q_full  out  1  queue holds DEPTH entries; parser must stall.
- deq_req  in  1  scheduler pops the head entry this cycle.
- head_valid  out  1  head entry present.
- head_opcode  out  parsed_op_t  opcode of the head entry.
- head_address  out  ADDRESS_WIDTH  address of the head entry.
- head_age  out  AGE_WIDTH  cycles the head entry has been queued; saturating.
- occupancy  out  $clog2(DEPTH)+1  current entry count.
- drop_err  out  1  one-cycle pulse: request lost because the queue was full.
- illegal_err  out  1  one-cycle pulse: illegal opcode discarded.

## Operation
- Storage: circular buffer of DEPTH entries {opcode, address, age}, with write pointer wp, read pointer rp, and occupancy count cnt. Pointers wrap from DEPTH-1 to 0.
- Derived status: empty = (cnt==0), full = (cnt==DEPTH). Queue condition is EMPTY, PARTIAL or FULL, decoded from cnt.
- Accept condition: enq = op_ready_s & opcode!=3 & (!full | deq).
- Dequeue condition: deq = deq_req & !empty. A deq_req while empty is ignored with no error.
- Enqueue:
  - writes entry[wp] with age 0;
  - wp <= wp+1 mod DEPTH.
- Dequeue: rp <= rp+1 mod DEPTH.
- Count update:
  - cnt <= cnt + enq - deq;
  - simultaneous enq and deq leaves cnt unchanged, including when full and when empty. From empty, deq is 0, so only the enqueue takes effect.
- Ageing:
  - every valid entry not written this cycle increments its age each clock;
  - age saturates at 2^AGE_WIDTH-1 and never wraps.
- Illegal opcode: op_ready_s with opcode==3 is never stored, even if the queue has space. illegal_err <= 1 for that one cycle.
- Drop: op_ready_s with a legal opcode while full & !deq_req is not stored. drop_err <= 1 for that one cycle.
- Ordering: strict FIFO. There is no reordering, bypass or coalescing.

## Timing
- Reset (async assert on rst_n low, released synchronously to clk):
  - wp=rp=cnt=0, all ages 0;
  - head_valid=0, q_full=0, occupancy=0, drop_err=0, illegal_err=0;
  - head_opcode=0, head_address=0, head_age=0.
- Reset mid-operation discards all entries immediately. A request pending on the reset cycle is lost without an error pulse.
- Enqueue latency: a request accepted at edge N appears at the head (if the queue was empty) with head_valid=1 and head_age=0 in the cycle after edge N. head_age is 1 after edge N+1.
- Head outputs are combinational from entry[rp] and cnt (first-word fall-through). head_opcode, head_address and head_age read 0 while empty.
- Dequeue: deq_req sampled at edge N. The next entry (or head_valid=0) is visible after edge N.
- q_full, occupancy, drop_err and illegal_err are registered and reflect state after the most recent edge.
- Parser contract: while q_full=1 the parser holds op_ready_s low unless it observes a same-cycle deq_req. A violation produces drop_err, not corruption.

## Test plan
- Reset then single write: op_ready_s=1, opcode=1, address=32'h0000_1A40 for one cycle, deq_req=0.
  - Expect next cycle: head_valid=1, head_opcode=1, head_address=32'h0000_1A40, head_age=0, occupancy=1.
  - After 5 more idle cycles: head_age=5.
- Fill and order: enqueue 16 reads, addresses 0x100..0x10F.
  - Expect q_full=1 and occupancy=16.
  - A 17th op_ready_s gives drop_err=1 for one cycle and occupancy stays 16.
  - Draining with deq_req=1 for 16 cycles returns addresses 0x100..0x10F in order, then head_valid=0.
- Simultaneous enq/deq when full: with 16 entries held, op_ready_s and deq_req both high with address 0x200.
  - Expect occupancy=16, no drop_err, new head = 2nd entry.
  - 0x200 is dequeued 16th.
- Boundary at empty and wrap-around:
  - deq_req on an empty queue: no change, no error.
  - Enqueue and dequeue together on an empty queue: occupancy becomes 1.
  - Run 40 enqueue/dequeue pairs: pointers wrap, order is preserved.
- Illegal and saturation:
  - opcode=3 gives illegal_err for one cycle and occupancy unchanged.
  - One entry left for 300 cycles gives head_age=255 (saturated).
- Async reset mid-operation: pull rst_n low with 7 entries queued.
  - Expect head_valid=0, occupancy=0 and q_full=0 immediately, before the next clk edge.
